// File: rtl/retire_if.sv
// Retire-stage types and the execute<->retire/commit bundle.
// Master drives the execute-side inputs; slave is the retire stage.
package retire_pkg;
    typedef enum logic [4:0] {
        NOP, ADD, SUB, AND_OP, OR_OP, XOR_OP, SLT, SLTU,
        SLL, SRL, SRA, LUI, AUIPC,
        LB, LBU, LH, LHU, LW,
        SB, SH, SW,
        BEQ, BNE, BLT, BGE, JAL, JALR
    } iType_e;
endpackage

interface retire_if #(
    parameter int INSTRET_WIDTH = 64
);
    import retire_pkg::*;

    logic [31:0]            instruction_i;
    logic [31:0]            pc_i;
    iType_e                 instruction_operation_i;
    logic [1:0][31:0]       result_i;
    logic [2:0]             tag_i;
    logic                   jump_i;
    logic                   write_enable_i;
    logic [3:0]             mem_write_enable_i;
    logic                   exception_i;
    logic [31:0]            mem_data_i;
    logic                   mem_ready_i;

    logic                   regbank_write_enable_o;
    logic [4:0]             regbank_address_o;
    logic [31:0]            regbank_data_o;
    logic [3:0]             mem_write_enable_o;
    logic [31:0]            mem_address_o;
    logic [31:0]            mem_data_o;
    logic                   jump_o;
    logic [31:0]            jump_target_o;
    logic                   exception_o;
    logic [31:0]            exception_pc_o;
    logic [2:0]             current_tag_o;
    logic                   stall_o;
    logic [INSTRET_WIDTH-1:0] instret_o;

    modport slave (
        input  instruction_i, pc_i, instruction_operation_i, result_i,
        input  tag_i, jump_i, write_enable_i, mem_write_enable_i,
        input  exception_i, mem_data_i, mem_ready_i,
        output regbank_write_enable_o, regbank_address_o, regbank_data_o,
        output mem_write_enable_o, mem_address_o, mem_data_o,
        output jump_o, jump_target_o, exception_o, exception_pc_o,
        output current_tag_o, stall_o, instret_o
    );

    modport master (
        output instruction_i, pc_i, instruction_operation_i, result_i,
        output tag_i, jump_i, write_enable_i, mem_write_enable_i,
        output exception_i, mem_data_i, mem_ready_i,
        input  regbank_write_enable_o, regbank_address_o, regbank_data_o,
        input  mem_write_enable_o, mem_address_o, mem_data_o,
        input  jump_o, jump_target_o, exception_o, exception_pc_o,
        input  current_tag_o, stall_o, instret_o
    );
endinterface

// File: rtl/retire.sv
// Retire stage: liveness by tag, write-back, load extension,
// store handshake, jump/trap redirect and instret counting.
module retire #(
    parameter int INSTRET_WIDTH = 64
) (
    input  logic     clk,
    input  logic     reset,
    retire_if.slave  bus
);
    import retire_pkg::*;

    typedef enum logic {RUN, STORE_WAIT} state_e;

    state_e                   state_q, state_d;
    logic [2:0]               tag_q, tag_d;
    logic [INSTRET_WIDTH-1:0] instret_q, instret_d;

    logic        tag_hit, live, is_store, run;
    logic        stall, commit, redirect;
    logic [4:0]  rd;
    logic [1:0]  off;
    logic [31:0] shifted, wb_data;
    logic [7:0]  bval;
    logic [15:0] hval;
    logic        unused_instr;

    assign unused_instr = ^{bus.instruction_i[31:12], bus.instruction_i[6:0]};

    always_comb begin
        tag_hit  = bus.tag_i == tag_q;
        live     = tag_hit & ~bus.exception_i;
        is_store = bus.instruction_operation_i inside {SB, SH, SW};
        run      = state_q == RUN;
        rd       = bus.instruction_i[11:7];
        off      = bus.result_i[0][1:0];
        shifted  = bus.mem_data_i >> {off, 3'b000};
        bval     = shifted[7:0];
        hval     = off[1] ? bus.mem_data_i[31:16] : bus.mem_data_i[15:0];

        // a stalled store is already live; it finishes on the ready cycle
        stall    = live & is_store & ~bus.mem_ready_i;
        commit   = live & (is_store ? bus.mem_ready_i : run);
        redirect = (tag_hit & bus.exception_i) | (live & bus.jump_i & run);

        unique case (bus.instruction_operation_i)
            LB:      wb_data = {{24{bval[7]}}, bval};
            LBU:     wb_data = {24'b0, bval};
            LH:      wb_data = {{16{hval[15]}}, hval};
            LHU:     wb_data = {16'b0, hval};
            LW:      wb_data = bus.mem_data_i;
            default: wb_data = bus.result_i[0];
        endcase

        state_d   = stall ? STORE_WAIT : RUN;
        tag_d     = tag_q + 3'(redirect);
        instret_d = instret_q + INSTRET_WIDTH'(commit);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            tag_q     <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        bus.regbank_write_enable_o = 1'b0;
        bus.regbank_address_o      = '0;
        bus.regbank_data_o         = '0;
        bus.mem_write_enable_o     = '0;
        bus.mem_address_o          = '0;
        bus.mem_data_o             = '0;
        bus.jump_o                 = 1'b0;
        bus.jump_target_o          = '0;
        bus.exception_o            = 1'b0;
        bus.exception_pc_o         = '0;
        bus.current_tag_o          = '0;
        bus.stall_o                = 1'b0;
        bus.instret_o              = '0;
        if (!reset) begin
            bus.regbank_write_enable_o =
                live & bus.write_enable_i & (rd != 5'd0) & run;
            bus.regbank_address_o  = rd;
            bus.regbank_data_o     = wb_data;
            bus.mem_write_enable_o =
                (live & is_store) ? bus.mem_write_enable_i : 4'b0;
            bus.mem_address_o      = {bus.result_i[0][31:2], 2'b00};
            bus.mem_data_o         = bus.result_i[1];
            bus.jump_o             = live & bus.jump_i & run;
            bus.jump_target_o      = bus.result_i[1];
            bus.exception_o        = tag_hit & bus.exception_i;
            bus.exception_pc_o     = bus.pc_i;
            bus.current_tag_o      = tag_q;
            bus.stall_o            = stall;
            bus.instret_o          = instret_q;
        end
    end
endmodule

// File: tb/tb_retire.sv
// Bench for retire: table of single-cycle vectors through a scoreboard
// queue, plus hand sequences for store wait, redirects and reset.
module tb_retire;
    import retire_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    retire_if #(.INSTRET_WIDTH(64)) bus ();
    retire #(.INSTRET_WIDTH(64)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    typedef struct {
        iType_e      op;
        logic [4:0]  rd;
        logic [2:0]  tag;
        logic        we, jmp, exc;
        logic [31:0] r0, r1, md;
        logic [3:0]  mwe;
        logic        rdy;
        logic        e_we;
        logic [31:0] e_data;
        logic [3:0]  e_mwe;
        logic        e_jmp, e_exc, e_stall;
        logic [2:0]  e_tag;
        logic [63:0] e_inst;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    vec_t e;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(
        iType_e op, logic [4:0] rd, logic [2:0] tag,
        logic we, logic jmp, logic exc,
        logic [31:0] r0, logic [31:0] r1, logic [31:0] md,
        logic [3:0] mwe, logic rdy,
        logic e_we, logic [31:0] e_data, logic [3:0] e_mwe,
        logic e_jmp, logic e_exc, logic e_stall,
        logic [2:0] e_tag, logic [63:0] e_inst);
        vec_t v;
        v.op = op; v.rd = rd; v.tag = tag;
        v.we = we; v.jmp = jmp; v.exc = exc;
        v.r0 = r0; v.r1 = r1; v.md = md;
        v.mwe = mwe; v.rdy = rdy;
        v.e_we = e_we; v.e_data = e_data; v.e_mwe = e_mwe;
        v.e_jmp = e_jmp; v.e_exc = e_exc; v.e_stall = e_stall;
        v.e_tag = e_tag; v.e_inst = e_inst;
        return v;
    endfunction

    function automatic vec_t in_only(
        iType_e op, logic [4:0] rd, logic [2:0] tag,
        logic we, logic jmp, logic exc,
        logic [31:0] r0, logic [31:0] r1, logic [3:0] mwe, logic rdy);
        return mk(op, rd, tag, we, jmp, exc, r0, r1, 32'h0, mwe, rdy,
                  0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic drive(input vec_t v);
        bus.instruction_i           = {20'h0, v.rd, 7'h13};
        bus.instruction_operation_i = v.op;
        bus.tag_i                   = v.tag;
        bus.write_enable_i          = v.we;
        bus.jump_i                  = v.jmp;
        bus.exception_i             = v.exc;
        bus.result_i[0]             = v.r0;
        bus.result_i[1]             = v.r1;
        bus.mem_data_i              = v.md;
        bus.mem_write_enable_i      = v.mwe;
        bus.mem_ready_i             = v.rdy;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_we"},    64'(bus.regbank_write_enable_o), 0);
        chk({name, "_rfad"},  64'(bus.regbank_address_o), 0);
        chk({name, "_rfdat"}, 64'(bus.regbank_data_o), 0);
        chk({name, "_mem"},   {bus.mem_address_o, bus.mem_data_o}, 0);
        chk({name, "_mwe"},   64'(bus.mem_write_enable_o), 0);
        chk({name, "_jmp"},   {31'h0, bus.jump_o, bus.jump_target_o}, 0);
        chk({name, "_exc"},   {31'h0, bus.exception_o, bus.exception_pc_o}, 0);
        chk({name, "_tag"},   64'(bus.current_tag_o), 0);
        chk({name, "_stall"}, 64'(bus.stall_o), 0);
        chk({name, "_inst"},  bus.instret_o, 0);
    endtask

    initial begin
        // op rd tag we jmp exc r0 r1 md mwe rdy | we data mwe jmp exc stall | tag inst
        tbl.push_back(mk(ADD, 5, 0, 1, 0, 0, 32'h1234, 0, 0, 0, 1, 1, 32'h1234, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(LB, 6, 0, 1, 0, 0, 32'h2, 0, 32'h00F00000, 0, 1, 1, 32'hFFFFFFF0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(LBU, 6, 0, 1, 0, 0, 32'h2, 0, 32'h00F00000, 0, 1, 1, 32'h000000F0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(LH, 6, 0, 1, 0, 0, 32'h2, 0, 32'h80000000, 0, 1, 1, 32'hFFFF8000, 0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(LHU, 6, 0, 1, 0, 0, 32'h0, 0, 32'h1234ABCD, 0, 1, 1, 32'h0000ABCD, 0, 0, 0, 0, 0, 5));
        tbl.push_back(mk(LW, 6, 0, 1, 0, 0, 32'h0, 0, 32'hDEADBEEF, 0, 1, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 6));
        tbl.push_back(mk(ADD, 0, 0, 1, 0, 0, 32'h55, 0, 0, 0, 1, 0, 32'h55, 0, 0, 0, 0, 0, 7));
        tbl.push_back(mk(ADD, 5, 3, 1, 0, 0, 32'h66, 0, 0, 0, 1, 0, 32'h66, 0, 0, 0, 0, 0, 7));
        tbl.push_back(mk(SW, 0, 0, 0, 0, 0, 32'h103, 32'hAA, 0, 4'hF, 1, 0, 32'h103, 4'hF, 0, 0, 0, 0, 8));
        tbl.push_back(mk(SB, 0, 2, 0, 0, 0, 32'h10, 32'hBB, 0, 4'h1, 1, 0, 32'h10, 0, 0, 0, 0, 0, 8));
        tbl.push_back(mk(BEQ, 0, 0, 0, 1, 0, 32'h0, 32'h200, 0, 0, 1, 0, 32'h0, 0, 1, 0, 0, 1, 9));
        tbl.push_back(mk(LB, 7, 1, 1, 0, 0, 32'h3, 0, 32'h7F000000, 0, 1, 1, 32'h7F, 0, 0, 0, 0, 1, 10));
        tbl.push_back(mk(ADD, 5, 1, 1, 1, 1, 32'h0, 32'h300, 0, 0, 1, 0, 32'h0, 0, 0, 1, 0, 2, 10));
        tbl.push_back(mk(ADD, 5, 5, 1, 0, 1, 32'h0, 0, 0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 2, 10));
        for (int t = 2; t <= 6; t++)
            tbl.push_back(mk(JAL, 1, 3'(t), 1, 1, 0, 32'h8, 32'h400, 0, 0, 1,
                             1, 32'h8, 0, 1, 0, 0, 3'(t + 1), 64'(t + 9)));
        tbl.push_back(mk(BEQ, 0, 7, 0, 1, 0, 32'h0, 32'h200, 0, 0, 1, 0, 32'h0, 0, 1, 0, 0, 0, 16));
        tbl.push_back(mk(ADD, 5, 7, 1, 0, 0, 32'h9, 0, 0, 0, 1, 0, 32'h9, 0, 0, 0, 0, 0, 16));

        bus.pc_i = 32'h40;
        reset = 1'b1;
        drive(in_only(ADD, 5, 0, 1, 1, 0, 32'h1234, 32'h200, 4'hF, 1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        drive(in_only(NOP, 0, 4, 0, 0, 0, 0, 0, 0, 1));
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_inst", bus.instret_o, 0);

        foreach (tbl[i]) begin
            drive(tbl[i]);
            sb.push_back(tbl[i]);
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("vec%0d_out", i),
                64'({bus.regbank_write_enable_o, bus.regbank_data_o,
                     bus.mem_write_enable_o, bus.jump_o,
                     bus.exception_o, bus.stall_o}),
                64'({e.e_we, e.e_data, e.e_mwe, e.e_jmp, e.e_exc, e.e_stall}));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_tag", i), 64'(bus.current_tag_o), 64'(e.e_tag));
            chk($sformatf("vec%0d_inst", i), bus.instret_o, e.e_inst);
        end

        // store held off by memory for three cycles
        drive(in_only(SW, 0, 0, 0, 0, 0, 32'h103, 32'hCAFEBABE, 4'hF, 0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("sw_wait_stall", 64'(bus.stall_o), 1);
            chk("sw_wait_mwe", 64'(bus.mem_write_enable_o), 64'hF);
            chk("sw_wait_mem", {bus.mem_address_o, bus.mem_data_o},
                {32'h100, 32'hCAFEBABE});
            @(posedge clk);
            #1;
            chk("sw_wait_inst", bus.instret_o, 16);
        end
        bus.mem_ready_i = 1'b1;
        @(negedge clk);
        chk("sw_done_stall", 64'(bus.stall_o), 0);
        chk("sw_done_mwe", 64'(bus.mem_write_enable_o), 64'hF);
        @(posedge clk);
        #1;
        chk("sw_done_inst", bus.instret_o, 17);
        chk("sw_done_tag", 64'(bus.current_tag_o), 0);

        drive(in_only(BEQ, 0, 0, 0, 1, 0, 32'h0, 32'h300, 0, 1));
        @(negedge clk);
        chk("jmp", {31'h0, bus.jump_o, bus.jump_target_o}, {31'h0, 1'b1, 32'h300});
        @(posedge clk);
        #1;
        chk("jmp_tag", 64'(bus.current_tag_o), 1);
        chk("jmp_inst", bus.instret_o, 18);

        bus.pc_i = 32'h80;
        drive(in_only(ADD, 5, 1, 1, 0, 1, 32'h5, 0, 0, 1));
        @(negedge clk);
        chk("exc", {31'h0, bus.exception_o, bus.exception_pc_o}, {31'h0, 1'b1, 32'h80});
        chk("exc_we", 64'(bus.regbank_write_enable_o), 0);
        @(posedge clk);
        #1;
        chk("exc_tag", 64'(bus.current_tag_o), 2);
        chk("exc_inst", bus.instret_o, 18);

        // reset arrives while a store is waiting on memory
        drive(in_only(SH, 0, 2, 0, 0, 0, 32'h204, 32'h1, 4'h3, 0));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_wait_stall", 64'(bus.stall_o), 1);
        #1;
        reset = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        drive(in_only(ADD, 5, 0, 1, 0, 0, 32'h77, 0, 0, 1));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_tag", 64'(bus.current_tag_o), 0);
        chk("post_rst_inst", bus.instret_o, 0);
        chk("post_rst_we", 64'(bus.regbank_write_enable_o), 1);
        chk("post_rst_stall", 64'(bus.stall_o), 0);
        @(posedge clk);
        #1;
        chk("post_rst_count", bus.instret_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/retire.md
Name: retire

Overview:
- Fourth and final pipeline stage of the PUC-RS5 core. Sits directly downstream of the execute stage and consumes its registered outputs.
- Decides whether the instruction is live: tag match and no exception.
- Commits the instruction:
  - regbank write,
  - load extension/alignment,
  - store issue with a memory-ready handshake,
  - jump redirect.
- Maintains the current execution tag and the retired-instruction counter.

Parameters:
- INSTRET_WIDTH, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- instruction_i  in  32  instruction word from execute
- pc_i  in  32  PC from execute
- instruction_operation_i  in  iType_e  decoded operation
- result_i  in  32x2  [0]=ALU result/effective address, [1]=jump target or store data
- tag_i  in  3  instruction tag
- jump_i  in  1  branch/jump taken
- write_enable_i  in  1  instruction writes regbank
- mem_write_enable_i  in  4  byte-lane store enables
- exception_i  in  1  exception flagged upstream
- mem_data_i  in  32  load data word (read issued by execute one cycle earlier)
- mem_ready_i  in  1  memory accepts the store this cycle
- regbank_write_enable_o  out  1  regbank write strobe
- regbank_address_o  out  5  destination register (instruction_i[11:7])
- regbank_data_o  out  32  write-back data
- mem_write_enable_o  out  4  store byte enables
- mem_address_o  out  32  store address, word-aligned ({result_i[0][31:2],2'b00})
- mem_data_o  out  32  store data (result_i[1])
- jump_o  out  1  redirect fetch
- jump_target_o  out  32  redirect address (result_i[1])
- exception_o  out  1  trap request to CSR bank
- exception_pc_o  out  32  PC of trapping instruction
- current_tag_o  out  3  live tag, to fetch/decode
- stall_o  out  1  freeze upstream stages
- instret_o  out  INSTRET_WIDTH  retired-instruction count

Behaviour:
- Reset (async):
  - current_tag=0, state=RUN, instret=0.
  - All outputs 0 while reset is high.
- Liveness:
  - live = (tag_i == current_tag) & !exception_i.
  - Killed instruction (tag mismatch): no regbank write, no store, no jump, no exception, no count.
- Regbank write:
  - regbank_write_enable_o = live & write_enable_i & (rd != 0) & (state==RUN).
  - Combinational output, same cycle.
- Load data extension, byte offset off = result_i[0][1:0]:
  - LB: sign-extended byte off.
  - LBU: zero-extended byte off.
  - LH: sign-extended halfword off[1].
  - LHU: zero-extended halfword off[1].
  - LW: mem_data_i.
  - All other operations: regbank_data_o = result_i[0].
- Store FSM, states RUN and STORE_WAIT:
  - RUN, live store (SB/SH/SW):
    - drive mem_write_enable_o = mem_write_enable_i, plus address and data.
    - mem_ready_i=1: store completes, stay in RUN, stall_o=0.
    - mem_ready_i=0: go to STORE_WAIT, stall_o=1.
  - STORE_WAIT:
    - outputs held (inputs frozen by stall_o), stall_o=1.
    - On mem_ready_i=1: store completes, stall_o=0 that cycle, return to RUN.
  - Non-live store: mem_write_enable_o=0.
- Jump:
  - jump_o = live & jump_i & (state==RUN).
  - On jump, current_tag <= current_tag+1 at the clock edge, wrapping 7→0.
- Exception:
  - exception_o = (tag_i==current_tag) & exception_i.
  - exception_pc_o = pc_i.
  - current_tag increments (trap redirect); no write, store, or count.
  - If jump_i and exception_i are both set: exception wins, tag increments by exactly 1.
- instret:
  - Increments by 1 on each live instruction that completes: non-store in RUN, or store in the ready cycle.
  - Wraps at 2^INSTRET_WIDTH.
  - A stalled store counts once only.
- Reset mid-STORE_WAIT: FSM returns to RUN; the store is abandoned.

Test Plan:
- Tag 0, ADD, rd=5, result_i[0]=0x1234, write_enable_i=1 -> regbank_write_enable_o=1, address 5, data 0x1234, instret 0→1.
- LB, result_i[0][1:0]=2'b10, mem_data_i=0x00F00000 -> regbank_data_o=0xFFFFFFF0. LBU -> 0x000000F0. LH with off[1]=1, mem_data_i=0x80000000 -> 0xFFFF8000.
- SW at address 0x103, mem_ready_i low for 3 cycles -> mem_write_enable_o=4'b1111, address 0x100, stall_o=1 for 3 cycles then 0 on the ready cycle; instret +1 exactly once.
- BEQ taken at tag 7, target 0x200 -> jump_o=1, jump_target_o=0x200, current_tag wraps to 0. Following instruction with tag_i=7 and write_enable_i=1 -> no write, no count.
- Tag match, exception_i=1, jump_i=1, pc_i=0x40 -> exception_o=1, exception_pc_o=0x40, jump_o=0, current_tag +1, instret unchanged.
- Assert reset during STORE_WAIT -> outputs 0 immediately, state=RUN, current_tag=0, instret=0.
